// File: rtl/stream_pkg.sv
// Shared frame-stream definitions: FSM state encoding, FIFO sideband bit
// positions and the counter-width helper used by producers and consumers.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_e;

    localparam int SB_SOF = 0;
    localparam int SB_EOL = 1;
    localparam int SB_EOF = 2;
    localparam int SB_W   = 3;

    // Counter width for a 0..bound-1 range, never narrower than one bit.
    function automatic int cnt_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/frame_stream_gen_if.sv
// Pixel input handshake plus FIFO write port of the frame stream generator.
// master = generator side, slave = environment (source and FIFO) side.
interface frame_stream_gen_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          fifo_full;
    logic [DW-1:0] fifo_data;
    logic          fifo_wrreq;
    logic          fifo_sof;
    logic          fifo_eol;
    logic          fifo_eof;

    modport master (
        input  in_valid, in_data, fifo_full,
        output in_ready, fifo_data, fifo_wrreq, fifo_sof, fifo_eol, fifo_eof
    );

    modport slave (
        output in_valid, in_data, fifo_full,
        input  in_ready, fifo_data, fifo_wrreq, fifo_sof, fifo_eol, fifo_eof
    );
endinterface

// File: rtl/frame_pos_counter.sv
// Raster position tracker: column wraps at WIDTH-1 and bumps the row.
// Flags are combinational from the current position; adv/clr act next edge.
module frame_pos_counter
    import stream_pkg::*;
#(
    parameter int WIDTH  = 56,
    parameter int HEIGHT = 56
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      clr,
    input  logic                      adv,
    output logic [cnt_w(WIDTH)-1:0]   col,
    output logic [cnt_w(HEIGHT)-1:0]  row,
    output logic                      last_col,
    output logic                      last_pixel
);
    localparam int CW = cnt_w(WIDTH);
    localparam int RW = cnt_w(HEIGHT);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    assign col        = col_q;
    assign row        = row_q;
    assign last_col   = (col_q == CW'(WIDTH - 1));
    assign last_pixel = last_col && (row_q == RW'(HEIGHT - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (adv) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_pixel ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/frame_stream_gen.sv
// Streams one WIDTH x HEIGHT frame into a FIFO, then FLUSH_WORDS filler words.
// Writes land one cycle after acceptance; fifo_full drops in_ready and stalls flush.
module frame_stream_gen
    import stream_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int CHANNELS    = 1,
    parameter int WIDTH       = 56,
    parameter int HEIGHT      = 56,
    parameter int FLUSH_WORDS = WIDTH + 2,
    parameter int FLUSH_VALUE = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    frame_stream_gen_if.master bus,
    output logic               busy,
    output logic               frame_done
);
    localparam int DW = DWIDTH * CHANNELS;
    localparam int FW = cnt_w(FLUSH_WORDS);
    localparam logic [DWIDTH-1:0] FILL_LANE  = DWIDTH'(FLUSH_VALUE);
    localparam logic [DW-1:0]     FILL_WORD  = {CHANNELS{FILL_LANE}};
    localparam logic [FW-1:0]     FLUSH_LAST = FW'((FLUSH_WORDS > 0) ? FLUSH_WORDS - 1 : 0);

    stream_state_e   state_q, state_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            wr_q, wr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SB_W-1:0] sb_q, sb_d;
    logic            done_q, done_d;

    logic                     accept, start_ok, pos_adv, pos_clr;
    logic [cnt_w(WIDTH)-1:0]  col;
    logic [cnt_w(HEIGHT)-1:0] row;
    logic                     last_col, last_pixel;

    frame_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (pos_clr),
        .adv        (pos_adv),
        .col        (col),
        .row        (row),
        .last_col   (last_col),
        .last_pixel (last_pixel)
    );

    assign bus.in_ready   = (state_q == ST_STREAM) && !bus.fifo_full;
    assign bus.fifo_wrreq = wr_q;
    assign bus.fifo_data  = data_q;
    assign bus.fifo_sof   = sb_q[SB_SOF];
    assign bus.fifo_eol   = sb_q[SB_EOL];
    assign bus.fifo_eof   = sb_q[SB_EOF];
    assign busy           = (state_q == ST_STREAM) || (state_q == ST_FLUSH);
    assign frame_done     = done_q;

    assign accept = bus.in_valid && bus.in_ready;
    // The first DONE cycle (done_q high) refuses start so a restart needs a fresh pulse.
    assign start_ok = start && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && !done_q));

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wr_d        = 1'b0;
        data_d      = data_q;
        sb_d        = '0;
        done_d      = 1'b0;
        pos_adv     = 1'b0;
        pos_clr     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d     = ST_STREAM;
                    flush_cnt_d = '0;
                    pos_clr     = 1'b1;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    wr_d         = 1'b1;
                    data_d       = bus.in_data;
                    sb_d[SB_SOF] = (col == '0) && (row == '0);
                    sb_d[SB_EOL] = last_col;
                    sb_d[SB_EOF] = last_pixel;
                    pos_adv      = 1'b1;
                    if (last_pixel) begin
                        if (FLUSH_WORDS == 0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (!bus.fifo_full) begin
                    wr_d        = 1'b1;
                    data_d      = FILL_WORD;
                    flush_cnt_d = flush_cnt_q + FW'(1);
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        flush_cnt_d = '0;
                        pos_clr     = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            wr_q        <= 1'b0;
            data_q      <= '0;
            sb_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            sb_q        <= sb_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_frame_stream_gen.sv
// Scoreboard bench: a 4x2 RGB frame with 6 filler words and a 4x2 mono frame
// with no flush, covering stalls, mid-frame reset and start filtering.
module tb_frame_stream_gen;
    import stream_pkg::*;

    typedef struct {
        logic [23:0] d;
        logic        sof;
        logic        eol;
        logic        eof;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    logic start;
    logic b_start;
    logic a_busy, a_done, b_busy, b_done;

    int checks = 0;
    int errors = 0;
    int a_wr = 0;
    int b_wr = 0;
    int b_done_cnt = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    frame_stream_gen_if #(.DW(24)) a_if ();
    frame_stream_gen_if #(.DW(8))  b_if ();

    assign b_if.in_valid  = a_if.in_valid;
    assign b_if.in_data   = a_if.in_data[7:0];
    assign b_if.fifo_full = 1'b0;

    frame_stream_gen #(
        .DWIDTH(8), .CHANNELS(3), .WIDTH(4), .HEIGHT(2), .FLUSH_WORDS(6), .FLUSH_VALUE(0)
    ) dut_a (
        .clk(clk), .resetn(resetn), .start(start), .bus(a_if.master),
        .busy(a_busy), .frame_done(a_done)
    );

    frame_stream_gen #(
        .DWIDTH(8), .CHANNELS(1), .WIDTH(4), .HEIGHT(2), .FLUSH_WORDS(0), .FLUSH_VALUE(0)
    ) dut_b (
        .clk(clk), .resetn(resetn), .start(b_start), .bus(b_if.master),
        .busy(b_busy), .frame_done(b_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int k);
        return {8'(k + 2), 8'(k + 1), 8'(k)};
    endfunction

    function automatic exp_t pix_exp(input int k, input logic [23:0] d, input logic done);
        exp_t e;
        e.d    = d;
        e.sof  = (k == 1);
        e.eol  = (k == 4) || (k == 8);
        e.eof  = (k == 8);
        e.done = done;
        return e;
    endfunction

    // Monitor: pops and compares every FIFO write of both instances.
    always @(negedge clk) begin
        if (resetn) begin
            if (a_if.fifo_wrreq) begin
                a_wr++;
                if (qa.size() == 0) begin
                    chk("a_unexpected_write", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    chk("a_data", 32'(a_if.fifo_data), 32'(ea.d));
                    chk("a_sof", 32'(a_if.fifo_sof), 32'(ea.sof));
                    chk("a_eol", 32'(a_if.fifo_eol), 32'(ea.eol));
                    chk("a_eof", 32'(a_if.fifo_eof), 32'(ea.eof));
                    chk("a_frame_done", 32'(a_done), 32'(ea.done));
                end
            end else if (a_done) begin
                chk("a_frame_done_without_write", 1, 0);
            end
            if (b_if.fifo_wrreq) begin
                b_wr++;
                if (qb.size() == 0) begin
                    chk("b_unexpected_write", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    chk("b_data", 32'(b_if.fifo_data), 32'(eb.d));
                    chk("b_sof", 32'(b_if.fifo_sof), 32'(eb.sof));
                    chk("b_eol", 32'(b_if.fifo_eol), 32'(eb.eol));
                    chk("b_eof", 32'(b_if.fifo_eof), 32'(eb.eof));
                    chk("b_frame_done", 32'(b_done), 32'(eb.done));
                end
            end else if (b_done) begin
                chk("b_frame_done_without_write", 1, 0);
            end
            if (b_done) b_done_cnt++;
        end
    end

    task automatic drive_frame(input bit do_start, input bit with_b, input bit do_stall,
                               input bit mid_start, input int abort_at);
        int k = 1;
        int stall_left = 0;
        int ready_low = 0;
        bit stalled = 0;
        bit ms_done = 0;
        bit aborted = 0;
        if (do_start) begin
            @(posedge clk); #1;
            start = 1'b1;
            b_start = with_b;
            @(posedge clk); #1;
            start = 1'b0;
            b_start = 1'b0;
        end
        chk("busy_in_stream", 32'(a_busy), 1);
        a_if.in_valid = 1'b1;
        a_if.in_data  = pix(1);
        while (k <= 8 && !aborted) begin
            @(negedge clk);
            if (!a_if.in_ready) ready_low++;
            if (a_if.in_ready) begin
                qa.push_back(pix_exp(k, pix(k), 1'b0));
                if (b_if.in_ready) qb.push_back(pix_exp(k, 24'(pix(k) & 24'hff), k == 8));
                k++;
            end
            if (abort_at > 0 && k > abort_at) begin
                @(posedge clk); #1;
                chk("wrreq_before_reset", 32'(a_if.fifo_wrreq), 1);
                @(negedge clk); #1;
                resetn = 1'b0;
                a_if.in_valid = 1'b0;
                #1;
                chk("rst_async_wrreq", 32'(a_if.fifo_wrreq), 0);
                chk("rst_async_busy", 32'(a_busy), 0);
                chk("rst_async_in_ready", 32'(a_if.in_ready), 0);
                chk("rst_async_data", 32'(a_if.fifo_data), 0);
                chk("rst_queue_drained", 32'(qa.size()), 0);
                aborted = 1;
            end else begin
                @(posedge clk); #1;
                start = 1'b0;
                if (mid_start && k == 3 && !ms_done) begin
                    start = 1'b1;
                    ms_done = 1;
                end
                if (do_stall && k == 5 && !stalled) begin
                    a_if.fifo_full = 1'b1;
                    stall_left = 3;
                    stalled = 1;
                end else if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) a_if.fifo_full = 1'b0;
                end
                a_if.in_data = pix(k);
            end
        end
        a_if.in_valid = 1'b0;
        if (!aborted) begin
            chk("ready_low_cycles", 32'(ready_low), do_stall ? 32'd3 : 32'd0);
            for (int i = 1; i <= 6; i++) qa.push_back('{24'h0, 1'b0, 1'b0, 1'b0, i == 6});
        end
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (a_done) seen = 1;
        end
        chk(nm, 32'(seen), 1);
    endtask

    initial begin
        int base;
        resetn = 1'b0;
        start = 1'b0;
        b_start = 1'b0;
        a_if.in_valid = 1'b0;
        a_if.in_data = '0;
        a_if.fifo_full = 1'b0;
        #23;
        chk("reset_in_ready", 32'(a_if.in_ready), 0);
        chk("reset_wrreq", 32'(a_if.fifo_wrreq), 0);
        chk("reset_data", 32'(a_if.fifo_data), 0);
        chk("reset_sideband", 32'({a_if.fifo_sof, a_if.fifo_eol, a_if.fifo_eof}), 0);
        chk("reset_busy", 32'(a_busy), 0);
        chk("reset_frame_done", 32'(a_done), 0);
        chk("reset_b_wrreq", 32'(b_if.fifo_wrreq), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Plain frame on both instances; mono instance has no flush.
        base = a_wr;
        drive_frame(1, 1, 0, 0, 0);
        wait_done("f1_done_seen");
        @(negedge clk); #1;
        chk("f1_total_writes", 32'(a_wr - base), 14);
        chk("f1_queue_empty", 32'(qa.size()), 0);
        chk("f1_idle_after_done", 32'(a_busy), 0);
        chk("b_total_writes", 32'(b_wr), 8);
        chk("b_done_pulses", 32'(b_done_cnt), 1);
        chk("b_queue_empty", 32'(qb.size()), 0);

        // Three-cycle fifo_full stall at pixel 5.
        base = a_wr;
        drive_frame(1, 0, 1, 0, 0);
        wait_done("f2_done_seen");
        @(negedge clk); #1;
        chk("f2_total_writes", 32'(a_wr - base), 14);
        chk("f2_queue_empty", 32'(qa.size()), 0);

        // Reset after pixel 3, then a fresh full frame.
        drive_frame(1, 0, 0, 0, 3);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_reset_busy", 32'(a_busy), 0);
        base = a_wr;
        drive_frame(1, 0, 0, 0, 0);
        wait_done("f4_done_seen");
        @(negedge clk); #1;
        chk("f4_total_writes", 32'(a_wr - base), 14);

        // Start mid-stream and on DONE entry are ignored; next-cycle start works.
        base = a_wr;
        drive_frame(1, 0, 0, 1, 0);
        wait_done("f5_done_seen");
        start = 1'b1;
        @(posedge clk); #1;
        chk("start_on_done_entry_ignored", 32'(a_busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        drive_frame(0, 0, 0, 0, 0);
        wait_done("f6_done_seen");
        @(negedge clk); #1;
        chk("f5_f6_total_writes", 32'(a_wr - base), 28);
        chk("f6_queue_empty", 32'(qa.size()), 0);
        repeat (5) @(negedge clk);
        chk("b_no_extra_writes", 32'(b_wr), 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
